// File: rtl/hybrid_cache_line_mp.sv
// hybrid_cache_line_mp: one cache line of 2^LSBBITS bytes with RDPORTS
// fixed-priority read ports (port 0 highest), one byte-enabled write port
// and stall-tolerant word-by-word fill/flush transfers to the memory arbiter.
// Optional feature macro HYBRID_CACHE_DIRTYMASK_EN: keep a per-word dirty mask
// and write back only dirty words on flush.
module hybrid_cache_line_mp #(
    parameter int unsigned ADDRBITS   = 32,
    parameter int unsigned DATABITS   = 32,
    parameter int unsigned LSBBITS    = 7,
    parameter int unsigned RDPORTS    = 2,
    parameter int unsigned MAXHITBITS = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [RDPORTS*ADDRBITS-1:0]   rd_addr,
    input  logic [RDPORTS-1:0]            rd_req,
    output logic [RDPORTS-1:0]            rd_hit,
    output logic [RDPORTS-1:0]            rd_grant,
    output logic [RDPORTS-1:0]            rd_valid,
    output logic [DATABITS-1:0]           rd_data,
    input  logic [ADDRBITS-1:0]           wr_addr,
    input  logic [DATABITS-1:0]           wr_data,
    input  logic [DATABITS/8-1:0]         wr_be,
    input  logic                          wr_req,
    output logic                          wr_hit,
    input  logic                          ctl_fill,
    input  logic                          ctl_flush,
    input  logic [ADDRBITS-LSBBITS-1:0]   ctl_new_region,
    output logic                          ctl_ready,
    output logic                          ctl_dirty,
    output logic                          ctl_hit,
    output logic [MAXHITBITS-1:0]         ctl_hitcnt,
    output logic [ADDRBITS-1:0]           mem_addr,
    output logic [DATABITS-1:0]           mem_wdata,
    output logic                          mem_rdreq,
    output logic                          mem_wrreq,
    input  logic                          mem_stall,
    input  logic [DATABITS-1:0]           mem_rdata,
    input  logic                          mem_rdata_valid
);
    localparam int unsigned BYTES   = DATABITS / 8;
    localparam int unsigned OFFB    = $clog2(BYTES);
    localparam int unsigned WBITS   = LSBBITS - OFFB;
    localparam int unsigned WORDS   = 1 << WBITS;
    localparam int unsigned TAGBITS = ADDRBITS - LSBBITS;
    localparam logic [MAXHITBITS-1:0] MAXHITCNT = '1;

    localparam logic [1:0] S_CACHE = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;

    logic [1:0]          state_q, state_nxt;
    logic [TAGBITS-1:0]  tag_q, pend_tag_q;
    logic                pend_fill_q, empty_q;
    logic [WBITS-1:0]    iss_idx_q, rsp_idx_q, gnt_word, flush_word, wr_word;
    logic                iss_done_q, gnt_any, wr_en, wr_accept, flush_any, flush_last, fill_done;
    logic [DATABITS-1:0] line_q [WORDS];
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{rd_addr, wr_addr};
    assign wr_word   = wr_addr[OFFB +: WBITS];
    assign wr_hit    = wr_req && !empty_q && (wr_addr[ADDRBITS-1:LSBBITS] == tag_q);
    assign ctl_ready = (state_q == S_CACHE);
    assign ctl_hit   = (|rd_hit) || wr_hit;
    assign wr_en     = (state_q == S_CACHE) && wr_hit;
    assign wr_accept = (state_q == S_FLUSH) && flush_any && !mem_stall;
    assign fill_done = (state_q == S_FILL) && mem_rdata_valid && (rsp_idx_q == WBITS'(WORDS - 1));

    // Per-port tag match and fixed-priority grant (lowest index wins)
    always_comb begin
        rd_hit   = '0;
        rd_grant = '0;
        gnt_any  = 1'b0;
        gnt_word = '0;
        for (int i = 0; i < int'(RDPORTS); i++) begin
            rd_hit[i] = rd_req[i] && !empty_q &&
                        (rd_addr[i*ADDRBITS+LSBBITS +: TAGBITS] == tag_q);
            if (rd_hit[i] && ctl_ready && !gnt_any) begin
                rd_grant[i] = 1'b1;
                gnt_any     = 1'b1;
                gnt_word    = rd_addr[i*ADDRBITS+OFFB +: WBITS];
            end
        end
    end

`ifdef HYBRID_CACHE_DIRTYMASK_EN
    logic [WORDS-1:0] dmask_q, dmask_nxt, flush_onehot;

    // Flush walks dirty words only, lowest index first
    always_comb begin
        flush_word = '0;
        for (int i = int'(WORDS) - 1; i >= 0; i--) begin
            if (dmask_q[i]) flush_word = WBITS'(i);
        end
        flush_any    = |dmask_q;
        flush_onehot = WORDS'(1) << flush_word;
        dmask_nxt    = wr_accept ? (dmask_q & ~flush_onehot) : dmask_q;
        flush_last   = (state_q == S_FLUSH) && (dmask_nxt == '0);
    end

    // Per-word dirty mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 dmask_q <= '0;
        else if (state_q == S_FLUSH)  dmask_q <= dmask_nxt;
        else if (fill_done)           dmask_q <= '0;
        else if (wr_en)               dmask_q[wr_word] <= 1'b1;
    end
`else
    logic [WBITS-1:0] flush_idx_q;

    assign flush_word = flush_idx_q;
    assign flush_any  = 1'b1;
    assign flush_last = wr_accept && (flush_idx_q == WBITS'(WORDS - 1));

    // Flush walks every word of the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 flush_idx_q <= '0;
        else if (state_q != S_FLUSH)  flush_idx_q <= '0;
        else if (wr_accept)           flush_idx_q <= flush_idx_q + WBITS'(1);
    end
`endif

    // Next state and memory request generation
    always_comb begin
        state_nxt = state_q;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_CACHE: begin
                if (ctl_flush)     state_nxt = S_FLUSH;
                else if (ctl_fill) state_nxt = S_FILL;
            end
            S_FLUSH: begin
                mem_wrreq = flush_any;
                mem_addr  = ADDRBITS'({tag_q, flush_word}) << OFFB;
                mem_wdata = flush_any ? line_q[flush_word] : '0;
                if (flush_last) state_nxt = pend_fill_q ? S_FILL : S_CACHE;
            end
            S_FILL: begin
                mem_rdreq = !iss_done_q;
                mem_addr  = ADDRBITS'({tag_q, iss_idx_q}) << OFFB;
                if (fill_done) state_nxt = S_CACHE;
            end
            default: state_nxt = S_CACHE;
        endcase
    end

    // State, tag, status, hit counter, read response and fill counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_CACHE;
            tag_q       <= '0;
            pend_tag_q  <= '0;
            pend_fill_q <= 1'b0;
            empty_q     <= 1'b1;
            ctl_dirty   <= 1'b0;
            ctl_hitcnt  <= '0;
            rd_valid    <= '0;
            rd_data     <= '0;
            iss_idx_q   <= '0;
            iss_done_q  <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            rd_valid <= rd_grant;
            if (gnt_any) rd_data <= line_q[gnt_word];
            case (state_q)
                S_CACHE: begin
                    if (wr_en) ctl_dirty <= 1'b1;
                    if ((rd_req != '0) || wr_req) begin
                        if (ctl_hit) begin
                            if (ctl_hitcnt != MAXHITCNT) ctl_hitcnt <= ctl_hitcnt + 1'b1;
                        end else if (ctl_hitcnt != '0) begin
                            ctl_hitcnt <= ctl_hitcnt - 1'b1;
                        end
                    end
                    if (ctl_flush) begin
                        pend_fill_q <= ctl_fill;
                        pend_tag_q  <= ctl_new_region;
                    end else if (ctl_fill) begin
                        tag_q   <= ctl_new_region;
                        empty_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_last) begin
                        ctl_dirty   <= 1'b0;
                        empty_q     <= 1'b1;
                        pend_fill_q <= 1'b0;
                        if (pend_fill_q) tag_q <= pend_tag_q;
                        else             ctl_hitcnt <= '0;
                    end
                end
                S_FILL: begin
                    if (fill_done) begin
                        empty_q    <= 1'b0;
                        ctl_dirty  <= 1'b0;
                        ctl_hitcnt <= MAXHITCNT;
                    end
                end
                default: ;
            endcase
            if (state_q != S_FILL) begin
                iss_idx_q  <= '0;
                iss_done_q <= 1'b0;
                rsp_idx_q  <= '0;
            end else begin
                if (mem_rdreq && !mem_stall) begin
                    iss_idx_q <= iss_idx_q + WBITS'(1);
                    if (iss_idx_q == WBITS'(WORDS - 1)) iss_done_q <= 1'b1;
                end
                if (mem_rdata_valid) rsp_idx_q <= rsp_idx_q + WBITS'(1);
            end
        end
    end

    // Line storage: byte-lane write hits and in-order fill responses
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wr_be[b]) line_q[wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if ((state_q == S_FILL) && mem_rdata_valid) line_q[rsp_idx_q] <= mem_rdata;
    end
endmodule
